// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - qualified PSU/reset power sequencer FSM in the 32 kHz always-on domain.
// Optional power-good loss monitor in RST_REL/ON/RESET: define PWR_SEQ_PWRGD_MON_EN.
module pwr_seq_ctrl #(
   parameter int REQ_MIN  = 32,
   parameter int PWRGD_TO = 3277,
   parameter int RST_HOLD = 328,
   parameter int CNT_W    = 16
) (
   input  logic       i_clk_32k,
   input  logic       i_rst_n,
   input  logic       i_pson_req,
   input  logic       i_pwroff_req,
   input  logic       i_reset_req,
   input  logic       i_pwrgd,
   output logic       o_psu_on,
   output logic       o_sys_rst_n,
   output logic [2:0] o_state,
   output logic       o_fault
);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_PWR_UP  = 3'd1,
      ST_RST_REL = 3'd2,
      ST_ON      = 3'd3,
      ST_RESET   = 3'd4,
      ST_PWR_DN  = 3'd5,
      ST_FAULT   = 3'd6
   } state_e;

   localparam int RW = $clog2(REQ_MIN + 1);
   localparam logic [RW-1:0]    REQ_SAT   = RW'(REQ_MIN);
   localparam logic [RW-1:0]    REQ_LAST  = RW'(REQ_MIN - 1);
   localparam logic [CNT_W-1:0] PWRGD_LIM = CNT_W'(PWRGD_TO);
   localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TMR_MAX   = '1;

   localparam int IDX_PSON   = 0;
   localparam int IDX_RESET  = 1;
   localparam int IDX_PWROFF = 2;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             psu_on_q, rst_n_q, fault_q;
   logic             pwrgd_meta_q, pwrgd_q;
   logic [2:0]       req;
   logic [RW-1:0]    req_cnt_q [3];
   logic [2:0]       stb_q;
   logic             pwroff_stb, reset_stb, pson_stb;
   logic             timed;
   logic             mon_loss;

   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwrgd_meta_q <= 1'b0;
         pwrgd_q      <= 1'b0;
      end else begin
         pwrgd_meta_q <= i_pwrgd;
         pwrgd_q      <= pwrgd_meta_q;
      end
   end

   assign req = {i_pwroff_req, i_reset_req, i_pson_req};

   // Strobe is registered so it is high in the same cycle the counter first reads REQ_MIN.
   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 3; i++) req_cnt_q[i] <= '0;
         stb_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!req[i]) begin
               req_cnt_q[i] <= '0;
            end else if (req_cnt_q[i] != REQ_SAT) begin
               req_cnt_q[i] <= req_cnt_q[i] + 1'b1;
            end
            stb_q[i] <= req[i] && (req_cnt_q[i] == REQ_LAST);
         end
      end
   end

   assign pwroff_stb = stb_q[IDX_PWROFF];
   assign reset_stb  = stb_q[IDX_RESET] & ~stb_q[IDX_PWROFF];
   assign pson_stb   = stb_q[IDX_PSON] & ~stb_q[IDX_RESET] & ~stb_q[IDX_PWROFF];

`ifdef PWR_SEQ_PWRGD_MON_EN
   logic loss_q;

   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         loss_q <= 1'b0;
      end else begin
         loss_q <= ~pwrgd_q && (state_q inside {ST_RST_REL, ST_ON, ST_RESET});
      end
   end

   assign mon_loss = ~pwrgd_q & loss_q;
`else
   assign mon_loss = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:     if (pson_stb) state_d = ST_PWR_UP;
         ST_PWR_UP: begin
            if (pwroff_stb)               state_d = ST_PWR_DN;
            else if (pwrgd_q)             state_d = ST_RST_REL;
            else if (timer_q >= PWRGD_LIM) state_d = ST_FAULT;
         end
         ST_RST_REL, ST_RESET: begin
            if (pwroff_stb)               state_d = ST_PWR_DN;
            else if (mon_loss)            state_d = ST_FAULT;
            else if (timer_q >= HOLD_LIM) state_d = ST_ON;
         end
         ST_ON: begin
            if (pwroff_stb)     state_d = ST_PWR_DN;
            else if (mon_loss)  state_d = ST_FAULT;
            else if (reset_stb) state_d = ST_RESET;
         end
         ST_PWR_DN: begin
            if (!pwrgd_q)                  state_d = ST_OFF;
            else if (timer_q >= PWRGD_LIM) state_d = ST_FAULT;
         end
         ST_FAULT: begin
            if (pwroff_stb)    state_d = ST_OFF;
            else if (pson_stb) state_d = ST_PWR_UP;
         end
         default:    state_d = ST_OFF;
      endcase
   end

   assign timed = state_q inside {ST_PWR_UP, ST_RST_REL, ST_RESET, ST_PWR_DN};

   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timed && (timer_q != TMR_MAX)) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Outputs decode the next state so they change together with o_state.
   always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_OFF;
         timer_q  <= '0;
         psu_on_q <= 1'b0;
         rst_n_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         psu_on_q <= state_d inside {ST_PWR_UP, ST_RST_REL, ST_ON, ST_RESET};
         rst_n_q  <= (state_d == ST_ON);
         fault_q  <= (state_d == ST_FAULT);
      end
   end

   assign o_psu_on    = psu_on_q;
   assign o_sys_rst_n = rst_n_q;
   assign o_state     = state_q;
   assign o_fault     = fault_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed self-checking bench for pwr_seq_ctrl (REQ_MIN=4, PWRGD_TO=20, RST_HOLD=8).
module tb_pwr_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pson = 1'b0;
   logic       pwroff = 1'b0;
   logic       rreq = 1'b0;
   logic       pwrgd = 1'b0;
   logic       psu_on;
   logic       sys_rst_n;
   logic [2:0] state;
   logic       fault;

   int n_total = 0;
   int n_pass  = 0;

   pwr_seq_ctrl #(
      .REQ_MIN (4),
      .PWRGD_TO(20),
      .RST_HOLD(8),
      .CNT_W   (16)
   ) dut (
      .i_clk_32k   (clk),
      .i_rst_n     (rst_n),
      .i_pson_req  (pson),
      .i_pwroff_req(pwroff),
      .i_reset_req (rreq),
      .i_pwrgd     (pwrgd),
      .o_psu_on    (psu_on),
      .o_sys_rst_n (sys_rst_n),
      .o_state     (state),
      .o_fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Power-good already high before pson, so PWR_UP lasts exactly one cycle.
   task automatic pon_fast(input string tag);
      pwrgd = 1'b1;
      tick(3);
      pson = 1'b1;
      tick(5);
      check({tag, "_pwr_up"}, int'(state), 1);
      tick(1);
      check({tag, "_rst_rel"}, int'(state), 2);
      pson = 1'b0;
      tick(8);
      check({tag, "_on"}, int'(state), 3);
   endtask

   initial begin
      int low_cnt;
      int entries;
      int prev;

      tick(2);
      check("rst_state", int'(state), 0);
      check("rst_psu", int'(psu_on), 0);
      check("rst_sysrst", int'(sys_rst_n), 0);
      check("rst_fault", int'(fault), 0);
      rst_n = 1'b1;
      tick(2);

      pson = 1'b1;
      tick(3);
      pson = 1'b0;
      tick(5);
      check("glitch3_state", int'(state), 0);

      pson = 1'b1;
      tick(4);
      pson = 1'b0;
      check("pulse4_pre", int'(state), 0);
      tick(1);
      check("pulse4_state", int'(state), 1);
      check("pulse4_psu", int'(psu_on), 1);
      tick(20);
      check("to_before", int'(state), 1);
      tick(1);
      check("to_state", int'(state), 6);
      check("to_fault", int'(fault), 1);
      check("to_psu", int'(psu_on), 0);
      pwroff = 1'b1;
      tick(4);
      check("fclr_pre", int'(state), 6);
      pwroff = 1'b0;
      tick(1);
      check("fclr_state", int'(state), 0);
      check("fclr_fault", int'(fault), 0);

      pson = 1'b1;
      tick(4);
      check("pu_lat4", int'(psu_on), 0);
      tick(1);
      check("pu_lat5", int'(psu_on), 1);
      tick(5);
      pwrgd = 1'b1;
      pson = 1'b0;
      tick(2);
      check("pu_sync", int'(state), 1);
      tick(1);
      check("pu_rst_rel", int'(state), 2);
      tick(7);
      check("pu_hold7", int'(sys_rst_n), 0);
      tick(1);
      check("pu_rstn", int'(sys_rst_n), 1);
      check("pu_on", int'(state), 3);
      pson = 1'b1;
      tick(10);
      pson = 1'b0;
      check("pson_in_on", int'(state), 3);
      check("pson_in_on_psu", int'(psu_on), 1);

      low_cnt = 0;
      entries = 0;
      prev = 3;
      rreq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 30) rreq = 1'b0;
         tick(1);
         if (sys_rst_n == 1'b0) low_cnt++;
         if (state == 3'd4 && prev != 4) entries++;
         prev = int'(state);
      end
      check("rstp_low_cycles", low_cnt, 8);
      check("rstp_entries", entries, 1);
      check("rstp_back_on", int'(state), 3);

      pwroff = 1'b1;
      rreq = 1'b1;
      tick(4);
      check("arb_pre", int'(state), 3);
      tick(1);
      check("arb_state", int'(state), 5);
      check("arb_psu", int'(psu_on), 0);
      pwroff = 1'b0;
      rreq = 1'b0;
      pwrgd = 1'b0;
      tick(2);
      check("dn_wait", int'(state), 5);
      tick(1);
      check("dn_off", int'(state), 0);

      pon_fast("fast1");
      rst_n = 1'b0;
      #2;
      check("async_psu", int'(psu_on), 0);
      check("async_state", int'(state), 0);
      check("async_sysrst", int'(sys_rst_n), 0);
      tick(1);
      rst_n = 1'b1;
      pon_fast("fast2");

      pwrgd = 1'b0;
      tick(1);
      pwrgd = 1'b1;
      tick(5);
      check("mon_glitch1", int'(state), 3);
      pwrgd = 1'b0;
      tick(2);
      pwrgd = 1'b1;
      tick(4);
`ifdef PWR_SEQ_PWRGD_MON_EN
      check("mon_loss2_state", int'(state), 6);
      check("mon_loss2_psu", int'(psu_on), 0);
      check("mon_loss2_fault", int'(fault), 1);
`else
      check("mon_loss2_state", int'(state), 3);
      check("mon_loss2_psu", int'(psu_on), 1);
      check("mon_loss2_fault", int'(fault), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
